// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, access owner
// and the width of the latency down-counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time. req[0]/gnt[0] is fetch, req[1]/gnt[1] is data.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last == OWN_D) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency word memory between
// instruction fetch and load/store. Handshake is req & ready in IDLE only.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    owner_t              last_q, last_d;
    owner_t              own_q, own_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [31:0]         d_rdata_q, d_rdata_d;

    logic [1:0]          gnt;
    logic                resp_d;

    // Byte-offset and upper address bits are intentionally dropped.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    rr_arb2 u_rr_arb2 (
        .req  ({d_req, if_req}),
        .last (last_q),
        .en   (state_q == IDLE),
        .gnt  (gnt)
    );

    assign if_ready = gnt[0];
    assign d_ready  = gnt[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_d   = own_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = ISSUE;
                    last_d  = gnt[1] ? OWN_D : OWN_IF;
                    own_d   = gnt[1] ? OWN_D : OWN_IF;
                    we_d    = gnt[1] & d_we;
                    addr_d  = gnt[1] ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
                    wdata_d = gnt[1] ? d_wdata : 32'h0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = LAT_M1;
            end
            WAIT: begin
                // Memory data is valid during the final WAIT cycle.
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // All outputs are decoded from the next state so they leave flops.
        mem_en_d    = (state_d == ISSUE);
        mem_we_d    = mem_en_d & we_d;
        mem_addr_d  = mem_en_d ? addr_d : '0;
        mem_wdata_d = mem_en_d ? wdata_d : 32'h0;

        resp_d      = (state_d == RESP);
        if_rvalid_d = resp_d & (own_d == OWN_IF);
        d_rvalid_d  = resp_d & (own_d == OWN_D);
        if_rdata_d  = if_rvalid_d ? rdata_d : 32'h0;
        d_rdata_d   = (d_rvalid_d && !we_d) ? rdata_d : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= OWN_D;
            own_q       <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            own_q       <= own_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, fixed-latency unified word memory between the instruction-fetch port and the load/store data port of the multi-cycle MIPS core. It has one outstanding access at a time. A 2-way round-robin decides between simultaneous requests, and a small FSM sequences issue, wait and response. It sits between the core's IF/MEM control and the memory array, which is indexed by word address (byte address bits [ADDR_W+1:2]).

## Interface
- ADDR_W, 8, word-address width presented to memory
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (1..7)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until granted
- if_addr  in  32  fetch byte address
- if_ready  out  1  fetch grant; handshake = if_req & if_ready
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  data grant
- d_rvalid  out  1  one-cycle completion pulse, for loads and stores
- d_rdata  out  32  load data; 0 on store completion
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_en

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on any handshake.
  - ISSUE → WAIT.
  - WAIT counts MEM_LAT−1 down, then → RESP. With MEM_LAT=1, WAIT lasts one cycle.
  - RESP → IDLE.
- Grants are raised only in IDLE and only toward the chosen requester. At most one of if_ready/d_ready is high in a cycle. Grants are combinational from the req inputs and the last_grant register.
- Arbitration:
  - A single requester is granted.
  - When both request, the one not in last_grant wins.
  - last_grant updates on each handshake.
  - Reset value is last_grant=DATA, so fetch wins the first tie.
- On a handshake, the owner, we, word address (addr[ADDR_W+1:2]) and wdata are captured.
  - addr[1:0] is ignored.
  - Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
  - if_* accesses are always reads.
- ISSUE drives mem_en=1, plus mem_we, mem_addr and mem_wdata from the capture registers. All mem_* signals are 0 in every other state.
- In the last WAIT cycle, mem_rdata is registered into rdata_q.
- RESP pulses the owner's rvalid.
  - For a load or fetch, rdata = rdata_q.
  - For a store, d_rdata = 0.
  - The non-owner's rvalid is 0.
- Dropping req before a grant is legal; no access occurs.
- Requests arriving in ISSUE, WAIT or RESP wait for IDLE.
- Reset at any time, including mid-access, returns the FSM to IDLE. No rvalid is produced for the aborted access.
- Reset values: all outputs 0, state=IDLE, capture registers 0, rdata_q 0.

## Timing
- Handshake in cycle t (IDLE).
- t+1: ISSUE, mem_en=1.
- t+1+MEM_LAT: WAIT ends, rdata_q captured.
- t+2+MEM_LAT: RESP, rvalid=1.
- Request-to-rvalid latency is MEM_LAT+2 cycles. The next grant comes no earlier than t+3+MEM_LAT, which gives back-to-back period MEM_LAT+3 (4 cycles at MEM_LAT=1).
- Outputs in RESP are registered. if_ready/d_ready are combinational, with no path from mem_rdata.

## Structure
- Package mem_arb_pkg holds:
  - state encoding IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - owner encoding OWN_IF=1'b0, OWN_D=1'b1
  - WAIT counter width 3 bits
- Sub-module rr_arb2 (inputs req[1:0], last, en; outputs gnt[1:0]) holds the combinational pick. The FSM, counter and capture registers stay in mem_arbiter.

## Test plan
- Reset then single fetch:
  - Memory word 1 = 32'h00001026; hold if_req with if_addr=32'h4.
  - Required: if_ready high in the same cycle, mem_en/mem_addr=8'd1 one cycle later, if_rvalid with 32'h00001026 exactly 3 cycles after the handshake (MEM_LAT=1).
- Simultaneous requests held continuously, if_addr=0, d_addr=8, load:
  - Required: grants alternate IF, D, IF, D, one every 4 cycles, fetch first after reset, never both grants high.
- Store then load:
  - d_we=1, d_addr=32'h10, d_wdata=32'hDEADBEEF.
  - Required: mem_we=1 with mem_addr=4, d_rvalid with d_rdata=0.
  - A following load of 32'h10 returns 32'hDEADBEEF.
- Address wrap/misalignment:
  - if_addr=32'h0000_0406 (ADDR_W=8).
  - Required: mem_addr=8'd1.
- Reset during WAIT of a load:
  - Required: all outputs 0 on the reset edge, no d_rvalid afterwards; the next fetch completes normally with fetch priority.
- MEM_LAT=3 build:
  - Required: rvalid 5 cycles after the handshake, mem_en high for exactly one cycle.
